// File: rtl/irda_mir_tx_if.sv
// Purpose : Bundles the MIR transmitter's command, FIFO and serial-line signals.
// Latency : None; wires only.
// Backpressure: None; FIFO flow is the txfifo_empty / txfifo_remove pop handshake.
// Ports (slave = transmitter side):
//   in : mir_txbit_enable, mir_tx_start, mir_tx_restart, mir_tx_len[15:0],
//        txfifo_dat_o[31:0], txfifo_empty
//   out: txfifo_remove, tx_o, mir_tx_busy, mir_tx_done, mir_tx_underrun
interface irda_mir_tx_if;
  logic        mir_txbit_enable;
  logic        mir_tx_start;
  logic        mir_tx_restart;
  logic [15:0] mir_tx_len;
  logic [31:0] txfifo_dat_o;
  logic        txfifo_empty;
  logic        txfifo_remove;
  logic        tx_o;
  logic        mir_tx_busy;
  logic        mir_tx_done;
  logic        mir_tx_underrun;

  // Controller / FIFO / modulator side.
  modport master (
    output mir_txbit_enable, mir_tx_start, mir_tx_restart, mir_tx_len,
           txfifo_dat_o, txfifo_empty,
    input  txfifo_remove, tx_o, mir_tx_busy, mir_tx_done, mir_tx_underrun
  );

  // Transmitter side.
  modport slave (
    input  mir_txbit_enable, mir_tx_start, mir_tx_restart, mir_tx_len,
           txfifo_dat_o, txfifo_empty,
    output txfifo_remove, tx_o, mir_tx_busy, mir_tx_done, mir_tx_underrun
  );
endinterface

// File: rtl/irda_mir_tx.sv
// Purpose : MIR frame serialiser: STA_COUNT x 0x7E, bit-stuffed data + CRC-CCITT16 FCS, one 0x7E.
// Latency : first flag bit on the first mir_txbit_enable tick after an accepted start;
//           one line bit per tick, done pulse on the tick after the last stop-flag bit.
// Backpressure: none on the line; an empty FIFO at a word fetch aborts the frame (underrun).
// Ports:
//   clk, wb_rst_i (async, active-high)
//   bus (irda_mir_tx_if.slave): command in, show-ahead FIFO head in, pop strobe out,
//                               registered line bit tx_o, busy/done/underrun status out.
module irda_mir_tx #(
  parameter int unsigned STA_COUNT = 2
) (
  input  logic         clk,
  input  logic         wb_rst_i,
  irda_mir_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STA,
    S_DATA,
    S_FCS,
    S_STO,
    S_ABORT
  } state_t;

  localparam logic [7:0]  FLAG     = 8'h7E;
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] STA_LAST = 16'(STA_COUNT - 1);

  state_t      state_q, state_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;
  logic [15:0] len_q, len_d;       // data bytes still to send
  logic [15:0] crc_q, crc_d;
  logic [31:0] word_q, word_d;     // word being serialised
  logic [3:0]  bit_q, bit_d;       // bit within byte/flag; 0..8 in STO/ABORT (8 = closing tick)
  logic [1:0]  byte_q, byte_d;     // byte within word
  logic [15:0] flag_q, flag_d;     // start flags already sent
  logic [4:0]  fcs_q, fcs_d;       // FCS bit pointer; 16 = only a trailing stuff bit remains
  logic [2:0]  ones_q, ones_d;     // consecutive transmitted ones

  logic        tick;
  logic        fetch;
  logic        remove;
  logic        data_bit;
  logic        fcs_bit;
  logic [15:0] crc_upd;

  assign tick = bus.mir_txbit_enable;

  // Current unstuffed bits and the serial CRC step for the data bit.
  assign data_bit = word_q[{byte_q, bit_q[2:0]}];
  assign fcs_bit  = ~crc_q[fcs_q[3:0]];
  assign crc_upd  = (crc_q >> 1) ^ ((crc_q[0] ^ data_bit) ? CRC_POLY : 16'h0000);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    len_d      = len_q;
    crc_d      = crc_q;
    word_d     = word_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    flag_d     = flag_q;
    fcs_d      = fcs_q;
    ones_d     = ones_q;
    fetch      = 1'b0;
    remove     = 1'b0;

    if (bus.mir_tx_restart) begin
      // Silent abort: line idle immediately, underrun flag kept for software.
      state_d = S_IDLE;
      tx_d    = 1'b1;
      len_d   = '0;
      crc_d   = '0;
      word_d  = '0;
      bit_d   = '0;
      byte_d  = '0;
      flag_d  = '0;
      fcs_d   = '0;
      ones_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.mir_tx_start) begin
            state_d    = S_STA;
            len_d      = bus.mir_tx_len;
            underrun_d = 1'b0;
            crc_d      = 16'hFFFF;
            bit_d      = '0;
            byte_d     = '0;
            flag_d     = '0;
            fcs_d      = '0;
            ones_d     = '0;
          end
        end

        S_STA: begin
          if (tick) begin
            tx_d = FLAG[bit_q[2:0]];
            if (bit_q[2:0] == 3'd7) begin
              bit_d  = '0;
              flag_d = flag_q + 16'd1;
              if (flag_q == STA_LAST) begin
                flag_d = '0;
                ones_d = '0;
                if (len_q != 16'd0) begin
                  fetch = 1'b1;
                end else begin
                  state_d = S_FCS;
                  fcs_d   = '0;
                end
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (ones_q == 3'd5) begin
              // Stuffed zero: pointer and CRC hold.
              tx_d   = 1'b0;
              ones_d = '0;
            end else begin
              tx_d   = data_bit;
              ones_d = data_bit ? ones_q + 3'd1 : 3'd0;
              crc_d  = crc_upd;
              if (bit_q[2:0] == 3'd7) begin
                bit_d  = '0;
                len_d  = len_q - 16'd1;
                byte_d = byte_q + 2'd1;
                if (len_q == 16'd1) begin
                  // Leftover bytes of the final word are dropped; ones count carries on.
                  state_d = S_FCS;
                  fcs_d   = '0;
                  byte_d  = '0;
                end else if (byte_q == 2'd3) begin
                  fetch = 1'b1;
                end
              end else begin
                bit_d = bit_q + 4'd1;
              end
            end
          end
        end

        S_FCS: begin
          if (tick) begin
            if (ones_q == 3'd5) begin
              tx_d   = 1'b0;
              ones_d = '0;
              if (fcs_q == 5'd16) begin
                state_d = S_STO;
                bit_d   = '0;
                fcs_d   = '0;
              end
            end else begin
              tx_d   = fcs_bit;
              ones_d = fcs_bit ? ones_q + 3'd1 : 3'd0;
              fcs_d  = fcs_q + 5'd1;
              // Last FCS bit: go straight to STO unless it completes a run of five ones,
              // in which case fcs_q parks at 16 and the stuff branch above closes out.
              if (fcs_q == 5'd15 && !(fcs_bit && ones_q == 3'd4)) begin
                state_d = S_STO;
                bit_d   = '0;
                fcs_d   = '0;
              end
            end
          end
        end

        S_STO: begin
          if (tick) begin
            if (bit_q == 4'd8) begin
              tx_d    = 1'b1;
              done_d  = 1'b1;
              state_d = S_IDLE;
              bit_d   = '0;
            end else begin
              tx_d  = FLAG[bit_q[2:0]];
              bit_d = bit_q + 4'd1;
            end
          end
        end

        S_ABORT: begin
          if (tick) begin
            tx_d = 1'b1;
            if (bit_q == 4'd8) begin
              state_d = S_IDLE;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase

      // Word fetch always lands on a tick (STA end or last bit of a word).
      if (fetch) begin
        bit_d  = '0;
        byte_d = '0;
        if (!bus.txfifo_empty) begin
          word_d  = bus.txfifo_dat_o;
          remove  = 1'b1;
          state_d = S_DATA;
        end else begin
          underrun_d = 1'b1;
          state_d    = S_ABORT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      len_q      <= '0;
      crc_q      <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      flag_q     <= '0;
      fcs_q      <= '0;
      ones_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      flag_q     <= flag_d;
      fcs_q      <= fcs_d;
      ones_q     <= ones_d;
    end
  end

  // Pop is combinational so it coincides with the edge that latches the head word.
  assign bus.txfifo_remove   = remove;
  assign bus.tx_o            = tx_q;
  assign bus.mir_tx_busy     = (state_q != S_IDLE);
  assign bus.mir_tx_done     = done_q;
  assign bus.mir_tx_underrun = underrun_q;

endmodule
